// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Holds the core in reset until a complete load session succeeds.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start                   : pulse that opens a load session (IDLE/DONE/ERR)
//   rx_data/rx_valid/rx_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   cpu_rst_n               : core reset, released only in DONE
//   busy/done/error         : session status
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit
// wrap-around checksum over all words and the CHK state.
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FLUSH, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_byte_cnt;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [23:0]           r_shift;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]           r_sum;
`endif

    logic                  w_take;
    logic                  w_start_ok;
    logic [31:0]           w_word;
    logic [15:0]           w_len_full;
    logic                  w_len_big;
    logic                  w_last_word;
    logic                  w_last_byte;

    // Bytes arrive LSB first, so each new byte lands in the top lane and
    // the previously collected bytes sit below it.
    assign w_word      = {rx_data, r_shift};
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_len_big   = {17'd0, w_len_full} > MAX_WORDS;
    assign w_last_word = (33'(r_word_idx) + 33'd1) == {17'd0, r_len};
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_take      = rx_valid && rx_ready;
    assign w_start_ok  = start && (r_state == S_IDLE ||
                                   r_state == S_DONE ||
                                   r_state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_take && r_byte_cnt[0]) begin
                    if (w_len_big) begin
                        w_next = S_ERR;
                    end else if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_take && w_last_byte && w_last_word) w_next = S_FLUSH;
            end
            S_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_next = S_CHK;
`else
                w_next = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_take && w_last_byte) begin
                    w_next = (w_word == r_sum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_shift    <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_byte_cnt <= 2'd0;
                r_word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum      <= 32'd0;
`endif
            end
            if (w_take) begin
                r_shift    <= w_word[31:8];
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_state == S_LEN) begin
                    if (!r_byte_cnt[0]) begin
                        r_len[7:0] <= rx_data;
                    end else begin
                        // Length done: data words start at byte 0.
                        r_len      <= w_len_full;
                        r_byte_cnt <= 2'd0;
                    end
                end
                if (r_state == S_DATA && w_last_byte) begin
                    r_we       <= 1'b1;
                    r_wdata    <= w_word;
                    r_addr     <= BASE_ADDR + (32'(r_word_idx) << 2);
                    r_word_idx <= r_word_idx + IDX_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum      <= r_sum + w_word;
`endif
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx_ready = (r_state == S_LEN) || (r_state == S_DATA) ||
                      (r_state == S_CHK);
    assign busy     = rx_ready || (r_state == S_FLUSH);
`else
    assign rx_ready = (r_state == S_LEN) || (r_state == S_DATA);
    assign busy     = rx_ready || (r_state == S_FLUSH);
`endif

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign cpu_rst_n  = (r_state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Reference: word list + wrap-around sum, memory image captured from writes.
module tb_imem_loader;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] mem [0:(1<<AW)-1];

    // Memory model: every cycle with the strobe high is one write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            mem[imem_addr[AW+1:2]] = imem_wdata;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_sum();
        logic [31:0] s;
        s = 32'd0;
        foreach (tx_q[i]) s = s + tx_q[i];
        return s;
    endfunction

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int n;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_accept: rx_ready=%b, required 1 within 50 cycles",
                     rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_body(input logic [15:0] n, input logic [31:0] chk,
                             input int maxgap);
        logic [31:0] w;
        send_byte(n[7:0], maxgap);
        send_byte(n[15:8], maxgap);
        foreach (tx_q[i]) begin
            w = tx_q[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], maxgap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) send_byte(chk[8*k +: 8], maxgap);
`else
        w = chk;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if ({rx_ready, imem_we, cpu_rst_n, busy, done, error} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl c%0d: rdy/we/rstn/busy/done/err=%b required 000000",
                         c, {rx_ready, imem_we, cpu_rst_n, busy, done, error});
            end
            n_tests++;
            if (imem_addr !== BASE || imem_wdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_bus c%0d: addr=%h wdata=%h required %h/0",
                         c, imem_addr, imem_wdata, BASE);
            end
        end
    endtask

    // Full session with either the reference program or random words.
    task automatic test_load(input string name, input int maxgap, input bit rnd);
        int          n;
        int          bad;
        logic [31:0] last;
        tx_q.delete();
        if (rnd) begin
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) tx_q.push_back($urandom);
        end else begin
            tx_q.push_back(32'h0050_0093);
            tx_q.push_back(32'h0010_0113);
        end
        last = tx_q[tx_q.size()-1];
        clear_writes();
        pulse_start();
        n_tests++;
        if (rx_ready !== 1'b1 || busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_resp: rdy=%b busy=%b rstn=%b required 1/1/0",
                     name, rx_ready, busy, cpu_rst_n);
        end
        send_body(16'(tx_q.size()), model_sum(), maxgap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_tests++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_latency: done=%b rstn=%b required 1/1",
                     name, done, cpu_rst_n);
        end
`else
        n_tests++;
        if (imem_we !== 1'b1 || imem_wdata !== last || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s last_write: we=%b wdata=%h done=%b required 1/%h/0",
                     name, imem_we, imem_wdata, done, last);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_latency: done=%b rstn=%b required 1/1",
                     name, done, cpu_rst_n);
        end
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (wa_q.size() != tx_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d",
                     name, wa_q.size(), tx_q.size());
        end else begin
            bad = 0;
            foreach (tx_q[i]) begin
                if (wa_q[i] !== BASE + 32'(4*i) || wd_q[i] !== tx_q[i]) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s write_content: first addr=%h data=%h, %0d bad, required %h/%h",
                         name, wa_q[0], wd_q[0], bad, BASE, tx_q[0]);
            end
        end
        n_tests++;
        if ({done, cpu_rst_n, error, busy, rx_ready} !== 5'b11000) begin
            n_fail++;
            $display("FAIL %s final_status: done/rstn/err/busy/rdy=%b required 11000",
                     name, {done, cpu_rst_n, error, busy, rx_ready});
        end
    endtask

    task automatic test_restart();
        pulse_start();
        n_tests++;
        if (cpu_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_drop: rstn=%b done=%b busy=%b required 0/0/1",
                     cpu_rst_n, done, busy);
        end
        tx_q.delete();
        tx_q.push_back($urandom);
        clear_writes();
        send_body(16'd1, model_sum(), 0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || wd_q.size() != 1) begin
            n_fail++;
            $display("FAIL restart_finish: done=%b writes=%0d required 1/1",
                     done, wd_q.size());
        end
    endtask

    task automatic test_zero_len();
        tx_q.delete();
        clear_writes();
        pulse_start();
        send_body(16'd0, 32'd0, 0);
        n_tests++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: done=%b rstn=%b err=%b required 1/1/0",
                     done, cpu_rst_n, error);
        end
        @(negedge clk);
        n_tests++;
        if (wa_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_writes: got %0d required 0", wa_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [15:0] n;
        n = 16'((1 << AW) + 1);
        clear_writes();
        pulse_start();
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        n_tests++;
        if ({error, done, cpu_rst_n, busy, rx_ready} !== 5'b10000) begin
            n_fail++;
            $display("FAIL overflow_status: err/done/rstn/busy/rdy=%b required 10000",
                     {error, done, cpu_rst_n, busy, rx_ready});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (wa_q.size() != 0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_writes: writes=%0d err=%b required 0/1",
                     wa_q.size(), error);
        end
    endtask

    task automatic test_full_memory();
        int bad;
        tx_q.delete();
        for (int i = 0; i < (1 << AW); i++) tx_q.push_back($urandom);
        clear_writes();
        pulse_start();
        send_body(16'(1 << AW), model_sum(), 0);
        repeat (3) @(negedge clk);
        bad = 0;
        if (wd_q.size() == tx_q.size()) begin
            foreach (tx_q[i]) if (wd_q[i] !== tx_q[i] || wa_q[i] !== BASE + 32'(4*i)) bad++;
        end else begin
            bad = -1;
        end
        n_tests++;
        if (bad != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_memory: writes=%0d bad=%0d done=%b required %0d/0/1",
                     wd_q.size(), bad, done, tx_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        tx_q.delete();
        tx_q.push_back(32'h0050_0093);
        tx_q.push_back(32'h0010_0113);
        clear_writes();
        pulse_start();
        send_body(16'd2, 32'hDEAD_BEEF, 0);
        n_tests++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chk_status: err=%b done=%b rstn=%b required 1/0/0",
                     error, done, cpu_rst_n);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (wd_q.size() != 2 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chk_writes: writes=%0d rstn=%b required 2/0",
                     wd_q.size(), cpu_rst_n);
        end
        test_load("after_bad_chk", 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        tx_q.delete();
        tx_q.push_back($urandom);
        tx_q.push_back($urandom);
        clear_writes();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        send_byte(tx_q[0][7:0], 0);
        pulse_start();
        send_byte(tx_q[0][15:8], 0);
        send_byte(tx_q[0][23:16], 0);
        send_byte(tx_q[0][31:24], 0);
        for (int k = 0; k < 4; k++) send_byte(tx_q[1][8*k +: 8], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [31:0] s;
            s = model_sum();
            for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8], 0);
        end
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || wd_q.size() != 2 || wd_q[wd_q.size()-1] !== tx_q[1]) begin
            n_fail++;
            $display("FAIL start_ignored: done=%b writes=%0d required 1/2",
                     done, wd_q.size());
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] w0;
        w0 = $urandom;
        clear_writes();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rx_ready, imem_we, cpu_rst_n, busy, done, error} !== 6'b0 ||
            imem_addr !== BASE || imem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_values: ctrl=%b addr=%h wdata=%h required 0/%h/0",
                     {rx_ready, imem_we, cpu_rst_n, busy, done, error},
                     imem_addr, imem_wdata, BASE);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem[0] !== w0 || wd_q.size() != 1) begin
            n_fail++;
            $display("FAIL rst_mid_kept: mem0=%h writes=%0d required %h/1",
                     mem[0], wd_q.size(), w0);
        end
        test_load("after_rst", 2, 1'b1);
    endtask

    task automatic test_start_with_rst();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_rst: busy=%b rdy=%b required 0/0",
                     busy, rx_ready);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_load("back_to_back", 0, 1'b0);
        test_restart();
        test_load("gaps_ref", 5, 1'b0);
        for (int i = 0; i < 5; i++) test_load("gaps_rand", 5, 1'b1);
        test_zero_len();
        test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_start_ignored();
        test_rst_mid();
        test_start_with_rst();
        test_full_memory();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
